// File: rtl/sw_input_cond_pkg.sv
// sw_pkg: shared constants and types for the stopwatch input conditioner.
//   DEBOUNCE_DEFAULT    - stable cycles before a debounced level changes
//                         (5 ms at 100 MHz)
//   SYNC_STAGES_DEFAULT - flip-flops per input synchroniser
//   sw_idx_e            - index of each raw input in the conditioner's vectors
package sw_pkg;

    localparam int DEBOUNCE_DEFAULT    = 500000;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int NUM_INPUTS          = 4;

    typedef enum logic [1:0] {
        IDX_PAUSE = 2'd0,
        IDX_CLEAR = 2'd1,
        IDX_ADJ   = 2'd2,
        IDX_SEL   = 2'd3
    } sw_idx_e;

endpackage

// File: rtl/sw_input_cond_if.sv
// sw_input_cond_if: board-side bundle of the stopwatch input conditioner.
//   BTN_PAUSE, BTN_CLEAR, SW_ADJ, SW_SEL - raw asynchronous buttons/switches
//   PAUSE, CLEAR, ADJ, SEL               - conditioned, registered controls
// master: the side that drives the raw inputs and consumes the controls.
// slave : the conditioner itself.
interface sw_input_cond_if;

    logic BTN_PAUSE;
    logic BTN_CLEAR;
    logic SW_ADJ;
    logic SW_SEL;
    logic PAUSE;
    logic CLEAR;
    logic ADJ;
    logic SEL;

    modport master (
        output BTN_PAUSE, BTN_CLEAR, SW_ADJ, SW_SEL,
        input  PAUSE, CLEAR, ADJ, SEL
    );

    modport slave (
        input  BTN_PAUSE, BTN_CLEAR, SW_ADJ, SW_SEL,
        output PAUSE, CLEAR, ADJ, SEL
    );

endinterface

// File: rtl/sw_input_cond_debounce.sv
// sw_debounce: synchronises one raw asynchronous input and debounces it.
//   clk   - system clock, rising edge
//   RESET - asynchronous active-high reset
//   raw   - raw asynchronous input
//   level - debounced stable level d
//   rise  - high for the single cycle after level goes 0 -> 1
// A new level is accepted only after the synchronised input has differed
// from the current level for DEBOUNCE_CYCLES consecutive cycles; any bounce
// back to the current level restarts the count.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic RESET,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   level_r;
    logic                   level_q_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   sync_out_s;
    logic                   level_nxt_s;
    logic [CNT_W-1:0]       cnt_nxt_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain: shift the raw input in at the low end.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce next-state: count consecutive disagreeing cycles, accept on the last.
    always_comb begin
        level_nxt_s = level_r;
        cnt_nxt_s   = cnt_r;
        if (sync_out_s == level_r) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
            level_nxt_s = sync_out_s;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Debounce state registers, plus a one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            level_r   <= 1'b0;
            level_q_r <= 1'b0;
            cnt_r     <= CNT_ZERO;
        end else begin
            level_r   <= level_nxt_s;
            level_q_r <= level_r;
            cnt_r     <= cnt_nxt_s;
        end
    end

    assign level = level_r;
    assign rise  = level_r & ~level_q_r;

endmodule

// File: rtl/sw_input_cond.sv
// sw_input_cond: stopwatch input conditioner.
//   clk   - system clock, rising edge
//   RESET - asynchronous active-high reset for every flop
//   io    - sw_input_cond_if.slave:
//             BTN_PAUSE/BTN_CLEAR/SW_ADJ/SW_SEL in (raw, asynchronous)
//             PAUSE (1 = paused), CLEAR (one-cycle pulse), ADJ, SEL out
// Each raw input is debounced independently. A debounced clear press pulses
// CLEAR and forces run state (PAUSE = 0) on the same edge, overriding a
// simultaneous pause press; a debounced pause press toggles PAUSE.
module sw_input_cond
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic           clk,
    input  logic           RESET,
    sw_input_cond_if.slave io
);

    logic [NUM_INPUTS-1:0] raw_s;
    logic [NUM_INPUTS-1:0] level_s;
    logic [NUM_INPUTS-1:0] rise_s;

    logic pause_r;
    logic clear_r;
    logic adj_r;
    logic sel_r;
    logic pause_nxt_s;
    logic clear_nxt_s;

    assign raw_s[IDX_PAUSE] = io.BTN_PAUSE;
    assign raw_s[IDX_CLEAR] = io.BTN_CLEAR;
    assign raw_s[IDX_ADJ]   = io.SW_ADJ;
    assign raw_s[IDX_SEL]   = io.SW_SEL;

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_deb
        sw_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_deb (
            .clk   (clk),
            .RESET (RESET),
            .raw   (raw_s[gi]),
            .level (level_s[gi]),
            .rise  (rise_s[gi])
        );
    end

    // Run/pause and clear next-state; clear has priority over pause.
    always_comb begin
        pause_nxt_s = pause_r;
        clear_nxt_s = 1'b0;
        if (rise_s[IDX_CLEAR]) begin
            clear_nxt_s = 1'b1;
            pause_nxt_s = 1'b0;
        end else if (rise_s[IDX_PAUSE]) begin
            clear_nxt_s = 1'b0;
            pause_nxt_s = ~pause_r;
        end else begin
            clear_nxt_s = 1'b0;
            pause_nxt_s = pause_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pause_r <= 1'b0;
            clear_r <= 1'b0;
            adj_r   <= 1'b0;
            sel_r   <= 1'b0;
        end else begin
            pause_r <= pause_nxt_s;
            clear_r <= clear_nxt_s;
            adj_r   <= level_s[IDX_ADJ];
            sel_r   <= level_s[IDX_SEL];
        end
    end

    assign io.PAUSE = pause_r;
    assign io.CLEAR = clear_r;
    assign io.ADJ   = adj_r;
    assign io.SEL   = sel_r;

endmodule
